pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit; successor to the bare PC register.
//  Holds the fetch address and selects the next PC (increment, branch, jump, trap).
//  Supports stall/halt with a small run-control FSM and an optional return-address stack.
//  Sits between the fetch stage and instruction memory; its pc output drives the IMEM address.
// PARAMETERS
//  n            32            PC width in bits
//  INC          4             increment added to pc each advancing cycle
//  RESET_VECTOR 32'h0000_0000 pc value while in reset and on leaving reset
//  TRAP_VECTOR  32'h0000_0080 pc loaded on trap
//  RAS_DEPTH    4             return-address-stack entries (used only when PC_RAS_EN)
// PORTS
//  clk           in   1  clock; rising edge active
//  rst_n         in   1  asynchronous reset, active low
//  stall         in   1  hold pc this cycle (pipeline hazard)
//  halt          in   1  enter HALT; pc frozen
//  resume        in   1  leave HALT
//  branch_taken  in   1  load branch_target
//  branch_target in   n  branch destination
//  jump          in   1  load jump_target
//  jump_target   in   n  jump destination
//  trap          in   1  load TRAP_VECTOR
//  pc            out  n  current fetch address
//  pc_plus_inc   out  n  pc + INC, combinational, for link register
//  pc_valid      out  1  high when pc is a real fetch (RUN state, not stalled)
//  run_state     out  2  FSM state encoding (pc_state_t)
//  call/ret      in   1  push pc_plus_inc / pop into pc (PC_RAS_EN only)
//  ras_empty     out  1  stack empty (PC_RAS_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0, async): pc=RESET_VECTOR, state=BOOT, pc_valid=0, RAS cleared, ras_empty=1.
//  - FSM: BOOT -> RUN after exactly one clk with rst_n=1 (pc held); RUN -> HALT on halt;
//    HALT -> RUN on resume (pc unchanged); trap in any non-BOOT state -> RUN at TRAP_VECTOR.
//  - Next-pc priority, registered on clk (1-cycle latency):
//    trap > halt/HALT hold > jump > ret (RAS) > branch_taken > stall hold > pc+INC.
//  - Simultaneous trap and halt: trap wins, state=RUN. Simultaneous halt and resume in HALT: stay HALT.
//  - stall suppresses increment only; jump/branch/trap/ret still redirect during stall.
//  - Arithmetic is modulo 2^n: pc=2^n-INC increments to 0, no flag.
//  - Targets loaded as given; low two bits forced to 0 (word-aligned fetch).
//  - pc_valid = (state==RUN) && !stall && !halt.
//  - Reset asserted mid-operation: immediate return to reset values regardless of inputs.
// CONFIGURATION
//  PC_RAS_EN defined: call pushes pc_plus_inc into RAS (also performs jump to jump_target);
//   ret pops top into pc. Push when full overwrites oldest (circular); pop when empty
//   loads RESET_VECTOR and leaves RAS empty. call and ret together: ret pops, then call pushes.
//  PC_RAS_EN undefined: call/ret/ras_empty ports absent; ret priority slot removed.
// STRUCTURE
//  pc_pkg: pc_state_t enum {BOOT, RUN, HALT}, default vector constants, INC default.
//  Sub-module pc_ras (RAS_DEPTH circular stack, push/pop/empty/full) instantiated under PC_RAS_EN.
// TESTING
//  - Reset held 3 cycles then released -> pc=0, pc_valid=0 for 1 cycle, then 0,4,8,12.
//  - pc=0x10, stall for 2 cycles -> pc stays 0x10, pc_valid=0, then 0x14.
//  - pc=0x20, branch_taken=1, branch_target=0x103 -> next pc=0x100; jump+branch together -> jump_target.
//  - halt at pc=0x40 -> pc holds 0x40 in HALT 5 cycles; resume -> 0x44 next cycle; trap in HALT -> 0x80.
//  - n=8, INC=4: pc=0xFC -> next pc=0x00 (wrap).
//  - PC_RAS_EN, depth 4: 5 calls from 0x0,0x10,0x20,0x30,0x40 then 5 rets ->
//    0x44,0x34,0x24,0x14, then empty pop -> RESET_VECTOR; rst_n low mid-sequence -> ras_empty=1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter unit.
package pc_pkg;

  // Run-control states, visible on the run_state debug output.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam int          PC_WIDTH        = 32;
  localparam int          PC_INC          = 4;
  localparam int          PC_RAS_DEPTH    = 4;
  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VECTOR  = 32'h0000_0080;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; a pop when empty is ignored. A push and pop in the same cycle
// replaces the top entry (pop first, then push).
module pc_ras #(
  parameter int n     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [n-1:0] data,
  output logic [n-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [n-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW:0]   count;
  logic [PW-1:0] ptr_up;
  logic [PW-1:0] ptr_down;

  assign ptr_up   = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  assign ptr_down = (ptr == '0) ? PW'(DEPTH - 1) : ptr - 1'b1;
  assign top      = mem[ptr];
  assign empty    = (count == '0);
  assign full     = (count == (PW + 1)'(DEPTH));

  // Stack pointer, occupancy and storage update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && pop && !empty) begin
      mem[ptr] <= data;
    end else if (push) begin
      ptr         <= ptr_up;
      mem[ptr_up] <= data;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      ptr   <= ptr_down;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: fetch-address register, next-pc selection and a
// BOOT/RUN/HALT run-control FSM. Define PC_RAS_EN to add call/ret ports
// and a return-address stack (pc_ras).
// Control inputs are level-sampled every rising clk edge; there is no
// handshake, a request is acted on in the cycle it is presented.
module pc_unit
  import pc_pkg::*;
#(
  parameter int           n            = PC_WIDTH,
  parameter int           INC          = PC_INC,
  parameter logic [n-1:0] RESET_VECTOR = n'(PC_RESET_VECTOR),
  parameter logic [n-1:0] TRAP_VECTOR  = n'(PC_TRAP_VECTOR),
  parameter int           RAS_DEPTH    = PC_RAS_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         halt,
  input  logic         resume,
  input  logic         branch_taken,
  input  logic [n-1:0] branch_target,
  input  logic         jump,
  input  logic [n-1:0] jump_target,
  input  logic         trap,
`ifdef PC_RAS_EN
  input  logic         call,
  input  logic         ret,
  output logic         ras_empty,
`endif
  output logic [n-1:0] pc,
  output logic [n-1:0] pc_plus_inc,
  output logic         pc_valid,
  output logic [1:0]   run_state
);

  pc_state_t    state;
  pc_state_t    state_next;
  logic [n-1:0] pc_next;
  logic [n-1:0] jump_aligned;
  logic [n-1:0] branch_aligned;
  logic         do_jump;
  logic         unused_low_bits;

  // Fetch is word aligned, so the low two target bits are dropped.
  assign jump_aligned    = {jump_target[n-1:2], 2'b00};
  assign branch_aligned  = {branch_target[n-1:2], 2'b00};
  assign unused_low_bits = ^{jump_target[1:0], branch_target[1:0]};

  assign pc_plus_inc = pc + n'(INC);
  assign pc_valid    = (state == RUN) && !stall && !halt;
  assign run_state   = state;

`ifdef PC_RAS_EN
  logic         ras_push;
  logic         ras_pop;
  logic [n-1:0] ras_top;
  logic         unused_ras_full;

  // A call is a jump that also records the return address.
  assign do_jump = jump | call;

  pc_ras #(
    .n     (n),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ras_push),
    .pop   (ras_pop),
    .data  (pc_plus_inc),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (unused_ras_full)
  );
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  assign do_jump = jump;
`endif

  // State and pc registers; reset returns to BOOT at the reset vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_VECTOR;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Next state and next pc: trap > halt/HALT hold > jump > ret > branch > stall > increment.
  always_comb begin
    state_next = state;
    pc_next    = pc;
`ifdef PC_RAS_EN
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
`endif
    unique case (state)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        if (trap) begin
          pc_next = TRAP_VECTOR;
        end else if (halt) begin
          state_next = HALT;
        end else begin
`ifdef PC_RAS_EN
          ras_push = call;
          ras_pop  = ret;
`endif
          if (do_jump) begin
            pc_next = jump_aligned;
          end
`ifdef PC_RAS_EN
          else if (ret) begin
            pc_next = ras_empty ? RESET_VECTOR : ras_top;
          end
`endif
          else if (branch_taken) begin
            pc_next = branch_aligned;
          end else if (!stall) begin
            pc_next = pc_plus_inc;
          end
        end
      end
      HALT: begin
        if (trap) begin
          state_next = RUN;
          pc_next    = TRAP_VECTOR;
        end else if (resume && !halt) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = BOOT;
        pc_next    = RESET_VECTOR;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized
// traffic against a behavioural model. Covers the RAS when PC_RAS_EN is set.
module tb_pc_unit;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 0, halt = 0, resume = 0, branch_taken = 0, jump = 0, trap = 0;
  logic        call = 0, ret = 0;
  logic [31:0] branch_target = '0, jump_target = '0;
  logic [31:0] pc, pc_plus_inc;
  logic        pc_valid;
  logic [1:0]  run_state;
  logic        ras_empty;

  logic        jump8 = 1'b0;
  logic [7:0]  jump_target8 = '0;
  logic [7:0]  pc8, pc_plus_inc8;
  logic        pc_valid8;
  logic [1:0]  run_state8;

  // Behavioural model state.
  pc_state_t   m_state;
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic [31:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt), .resume(resume),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .trap(trap),
`ifdef PC_RAS_EN
    .call(call), .ret(ret), .ras_empty(ras_empty),
`endif
    .pc(pc), .pc_plus_inc(pc_plus_inc), .pc_valid(pc_valid), .run_state(run_state)
  );

  pc_unit #(.n(8), .INC(4), .RESET_VECTOR(8'h00), .TRAP_VECTOR(8'h80)) dut8 (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .halt(1'b0), .resume(1'b0),
    .branch_taken(1'b0), .branch_target(8'h00),
    .jump(jump8), .jump_target(jump_target8), .trap(1'b0),
`ifdef PC_RAS_EN
    .call(1'b0), .ret(1'b0), .ras_empty(),
`endif
    .pc(pc8), .pc_plus_inc(pc_plus_inc8), .pc_valid(pc_valid8), .run_state(run_state8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = BOOT;
    m_pc    = PC_RESET_VECTOR;
    m_ras.delete();
    exp_q.delete();
  endtask

  // One clock of the architectural rules, applied to the current inputs.
  task automatic model_step();
    logic [31:0] popped;
    if (m_state == BOOT) begin
      m_state = RUN;
    end else if (trap) begin
      m_state = RUN;
      m_pc    = PC_TRAP_VECTOR;
    end else if (m_state == HALT) begin
      if (resume && !halt) m_state = RUN;
    end else if (halt) begin
      m_state = HALT;
    end else begin
      popped = PC_RESET_VECTOR;
      if (ret && m_ras.size() > 0) popped = m_ras.pop_back();
      if (call) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > PC_RAS_DEPTH) void'(m_ras.pop_front());
      end
      if (jump || call)       m_pc = jump_target & ~32'd3;
      else if (ret)           m_pc = popped;
      else if (branch_taken)  m_pc = branch_target & ~32'd3;
      else if (!stall)        m_pc = m_pc + 32'd4;
    end
  endtask

  // driver: inputs are already set; check combinational outputs, clock, check registered outputs.
  task automatic step();
    logic exp_valid;
    #1;
    exp_valid = (m_state == RUN) && !stall && !halt;
    chk("pc_valid", {31'b0, pc_valid}, {31'b0, exp_valid});
    chk("pc_plus_inc", pc_plus_inc, m_pc + 32'd4);
    model_step();
    exp_q.push_back(m_pc);
    @(posedge clk);
    #1;
    chk("pc", pc, exp_q.pop_front());
    chk("run_state", {30'b0, run_state}, 32'(m_state));
`ifdef PC_RAS_EN
    chk("ras_empty", {31'b0, ras_empty}, {31'b0, (m_ras.size() == 0)});
`endif
  endtask

  task automatic idle();
    stall = 0; halt = 0; resume = 0; branch_taken = 0; jump = 0; trap = 0;
    call = 0; ret = 0;
  endtask

  // Asynchronous reset pulse between edges; outputs must return at once.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, PC_RESET_VECTOR);
    chk("rst_state", {30'b0, run_state}, 32'(BOOT));
    chk("rst_valid", {31'b0, pc_valid}, 32'd0);
`ifdef PC_RAS_EN
    chk("rst_ras_empty", {31'b0, ras_empty}, 32'd1);
`endif
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic goto(input logic [31:0] addr);
    idle();
    jump = 1; jump_target = addr;
    step();
    jump = 0;
  endtask

  initial begin
    model_reset();
    idle();
    // Reset held three cycles.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pc", pc, 32'h0);
    chk("reset_state", {30'b0, run_state}, 32'(BOOT));
    chk("reset_valid", {31'b0, pc_valid}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("boot_pc", pc, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("count_pc", pc, 32'(i * 4));
    end

    // Stall holds pc, suppresses pc_valid.
    goto(32'h10);
    stall = 1;
    repeat (2) begin
      step();
      chk("stall_pc", pc, 32'h10);
    end
    stall = 0;
    step();
    chk("after_stall", pc, 32'h14);

    // Branch target alignment; jump beats branch; redirect during stall.
    goto(32'h20);
    branch_taken = 1; branch_target = 32'h103;
    step();
    chk("branch_pc", pc, 32'h100);
    jump = 1; jump_target = 32'h200; branch_target = 32'h300; stall = 1;
    step();
    chk("jump_over_branch", pc, 32'h200);
    idle();

    // Halt, hold, resume, trap from HALT.
    goto(32'h40);
    halt = 1;
    step();
    chk("halt_state", {30'b0, run_state}, 32'(HALT));
    halt = 0;
    repeat (5) begin
      step();
      chk("halt_pc", pc, 32'h40);
    end
    halt = 1; resume = 1;
    step();
    chk("halt_resume_stay", {30'b0, run_state}, 32'(HALT));
    halt = 0;
    step();
    chk("resume_state", {30'b0, run_state}, 32'(RUN));
    resume = 0;
    step();
    chk("resume_pc", pc, 32'h44);
    halt = 1;
    step();
    halt = 0; trap = 1;
    step();
    chk("trap_pc", pc, 32'h80);
    halt = 1; trap = 1;
    step();
    chk("trap_halt_state", {30'b0, run_state}, 32'(RUN));
    idle();

    // Modulo wrap on the 8-bit instance; main unit stalls meanwhile.
    stall = 1;
    jump8 = 1; jump_target8 = 8'hFC;
    step();
    chk("wrap8_load", {24'b0, pc8}, 32'hFC);
    jump8 = 0;
    step();
    chk("wrap8_pc", {24'b0, pc8}, 32'h00);
    idle();

`ifdef PC_RAS_EN
    // Five calls into a four-deep stack, then five returns.
    mid_reset();
    step();
    for (int i = 0; i < 5; i++) begin
      call = 1; jump_target = 32'((i + 1) * 16);
      step();
    end
    call = 0; ret = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ret_pc", pc, 32'h44 - 32'(i * 16));
    end
    step();
    chk("ret_empty_pc", pc, PC_RESET_VECTOR);
    chk("ret_empty_flag", {31'b0, ras_empty}, 32'd1);
    ret = 0; call = 1; jump_target = 32'h300;
    step();
    call = 0;
    mid_reset();
    step();
    idle();
`endif

    // Randomized traffic with an occasional asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      halt          = ($urandom_range(0, 15) == 0);
      resume        = ($urandom_range(0, 2) == 0);
      branch_taken  = ($urandom_range(0, 4) == 0);
      jump          = ($urandom_range(0, 9) == 0);
      trap          = ($urandom_range(0, 31) == 0);
      branch_target = $urandom;
      jump_target   = $urandom;
`ifdef PC_RAS_EN
      call          = ($urandom_range(0, 7) == 0);
      ret           = ($urandom_range(0, 7) == 0);
`endif
      if (i == 200) mid_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
